plic_lite: RTL and testbench

//  Parametrised platform-level interrupt controller, successor to the single-line

---
 rtl/plic_lite.sv | 144 ++++++++++++++
 tb/tb_plic_lite.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_lite.sv
// plic_lite: compact platform-level interrupt controller.
// NSRC sources (IDs 1..NSRC) with programmable priority, enable and threshold
// drive ext_irq. Software claims and completes IDs through a pulse handshake.
// Optional build macro PLIC_EDGE_TRIG_EN adds per-source edge-triggered gateways
// selected by the edge_mode bitmap at 0x22. Without it, every source is level-triggered.
module plic_lite #(
  parameter int NSRC   = 8,
  parameter int PRIO_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic            cfg_we,
  input  logic [5:0]      cfg_addr,
  input  logic [31:0]     cfg_wdata,
  output logic [31:0]     cfg_rdata,
  input  logic            claim_req,
  output logic [4:0]      claim_id,
  output logic            claim_valid,
  input  logic            complete_req,
  input  logic [4:0]      complete_id,
  output logic            ext_irq
);

  logic [PRIO_W-1:0] prio_reg [1:NSRC];
  logic [NSRC-1:0]   enable_reg;
  logic [PRIO_W-1:0] threshold_reg;
  logic [NSRC-1:0]   pending_reg, pending_next;
  logic [NSRC-1:0]   in_flight_reg, in_flight_next;
  logic [NSRC-1:0]   eligible, set_req, claim_hit, complete_hit;
  logic [NSRC-1:0]   edge_mode_view;
  logic [4:0]        best_id;
  logic [4:0]        claim_id_reg;
  logic              claim_valid_reg;
  logic              ext_irq_reg;
  logic              unused_wdata;

  // Upper write-data bits are architecturally ignored.
  assign unused_wdata = ^cfg_wdata;

  assign claim_id    = claim_id_reg;
  assign claim_valid = claim_valid_reg;
  assign ext_irq     = ext_irq_reg;

`ifdef PLIC_EDGE_TRIG_EN
  logic [NSRC-1:0] edge_mode_reg;
  logic [NSRC-1:0] prev_src_reg;

  // Edge-mode bitmap and previous-sample register for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      edge_mode_reg <= '0;
      prev_src_reg  <= '0;
    end else begin
      prev_src_reg <= irq_src;
      if (cfg_we && cfg_addr == 6'h22) edge_mode_reg <= cfg_wdata[NSRC-1:0];
    end
  end

  assign edge_mode_view = edge_mode_reg;
`else
  assign edge_mode_view = '0;
`endif

  // Per-source gateway, eligibility and claim/complete hit decode.
  genvar gi;
  for (gi = 0; gi < NSRC; gi++) begin : g_src
    assign eligible[gi] = pending_reg[gi] & enable_reg[gi] &
                          (prio_reg[gi+1] > threshold_reg);
`ifdef PLIC_EDGE_TRIG_EN
    // Edge sources ignore in_flight; an edge while already pending just merges.
    assign set_req[gi] = edge_mode_reg[gi] ? (irq_src[gi] & ~prev_src_reg[gi])
                                           : (irq_src[gi] & ~in_flight_reg[gi]);
`else
    assign set_req[gi] = irq_src[gi] & ~in_flight_reg[gi];
`endif
    assign claim_hit[gi]    = claim_req & (best_id == 5'(gi + 1));
    assign complete_hit[gi] = complete_req & (complete_id == 5'(gi + 1));
    // A claim of this source overrides a simultaneous new request.
    assign pending_next[gi]   = claim_hit[gi] ? 1'b0 : (pending_reg[gi] | set_req[gi]);
    assign in_flight_next[gi] = claim_hit[gi] ? 1'b1 :
                                (complete_hit[gi] ? 1'b0 : in_flight_reg[gi]);
  end

  // Arbiter: highest priority wins; scanning upward with strict > keeps lowest ID on ties.
  always_comb begin
    logic [PRIO_W-1:0] best_prio;
    best_id   = '0;
    best_prio = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (eligible[i-1] && prio_reg[i] > best_prio) begin
        best_id   = 5'(i);
        best_prio = prio_reg[i];
      end
    end
  end

  // Configuration registers: priorities, enable bitmap, threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= NSRC; i++) prio_reg[i] <= '0;
      enable_reg    <= '0;
      threshold_reg <= '0;
    end else if (cfg_we) begin
      for (int i = 1; i <= NSRC; i++) begin
        if (cfg_addr == 6'(i)) prio_reg[i] <= cfg_wdata[PRIO_W-1:0];
      end
      if (cfg_addr == 6'h20) enable_reg    <= cfg_wdata[NSRC-1:0];
      if (cfg_addr == 6'h21) threshold_reg <= cfg_wdata[PRIO_W-1:0];
    end
  end

  // Combinational config readback; unmapped addresses read zero.
  always_comb begin
    cfg_rdata = '0;
    for (int i = 1; i <= NSRC; i++) begin
      if (cfg_addr == 6'(i)) cfg_rdata = 32'(prio_reg[i]);
    end
    case (cfg_addr)
      6'h20:   cfg_rdata = 32'(enable_reg);
      6'h21:   cfg_rdata = 32'(threshold_reg);
      6'h22:   cfg_rdata = 32'(edge_mode_view);
      default: ;
    endcase
  end

  // Pending/in-flight state, claim response and registered interrupt request.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg     <= '0;
      in_flight_reg   <= '0;
      claim_id_reg    <= '0;
      claim_valid_reg <= 1'b0;
      ext_irq_reg     <= 1'b0;
    end else begin
      pending_reg     <= pending_next;
      in_flight_reg   <= in_flight_next;
      claim_valid_reg <= claim_req;
      if (claim_req) claim_id_reg <= best_id;
      ext_irq_reg     <= (best_id != 5'd0);
    end
  end

endmodule

// File: tb/tb_plic_lite.sv
// Directed testbench for plic_lite (NSRC = 8, PRIO_W = 3).
module tb_plic_lite;

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [5:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        claim_req;
  logic [4:0]  claim_id;
  logic        claim_valid;
  logic        complete_req;
  logic [4:0]  complete_id;
  logic        ext_irq;

  int vectors;
  int miscompares;

  plic_lite #(.NSRC(8), .PRIO_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .cfg_we       (cfg_we),
    .cfg_addr     (cfg_addr),
    .cfg_wdata    (cfg_wdata),
    .cfg_rdata    (cfg_rdata),
    .claim_req    (claim_req),
    .claim_id     (claim_id),
    .claim_valid  (claim_valid),
    .complete_req (complete_req),
    .complete_id  (complete_id),
    .ext_irq      (ext_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("vec %0d %s obs=%0h exp=%0h", vectors, tag, obs, exp);
  endtask

  task automatic cfg_write(input logic [5:0] addr, input logic [31:0] data);
    cfg_we    = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    step();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  task automatic cfg_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    cfg_addr = addr;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask

  task automatic do_claim(input string tag, input logic [4:0] exp_id);
    claim_req = 1'b1;
    step();
    claim_req = 1'b0;
    chk({tag, "_id"}, 32'(claim_id), 32'(exp_id));
    chk({tag, "_vld"}, 32'(claim_valid), 32'd1);
  endtask

  task automatic do_complete(input logic [4:0] id);
    complete_req = 1'b1;
    complete_id  = id;
    step();
    complete_req = 1'b0;
    complete_id  = '0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    irq_src      = '0;
    cfg_we       = 1'b0;
    cfg_addr     = '0;
    cfg_wdata    = '0;
    claim_req    = 1'b0;
    complete_req = 1'b0;
    complete_id  = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_ext_irq", 32'(ext_irq), 32'd0);
    chk("rst_claim_id", 32'(claim_id), 32'd0);
    chk("rst_claim_vld", 32'(claim_valid), 32'd0);
    cfg_check("rst_enable", 6'h20, 32'd0);

    // Single source 3: two-cycle latency to ext_irq, claim drops it
    cfg_write(6'd3, 32'd2);
    cfg_write(6'h20, 32'h04);
    cfg_write(6'h21, 32'd0);
    cfg_check("rd_prio3", 6'd3, 32'd2);
    cfg_check("rd_unmapped", 6'h30, 32'd0);
    irq_src = 8'h04;
    step();
    chk("s3_lat1", 32'(ext_irq), 32'd0);
    step();
    chk("s3_lat2", 32'(ext_irq), 32'd1);
    do_claim("s3_claim", 5'd3);
    step();
    chk("s3_vld_pulse", 32'(claim_valid), 32'd0);
    chk("s3_irq_drop", 32'(ext_irq), 32'd0);
    irq_src = '0;
    do_complete(5'd3);
    step();
    chk("s3_after_cpl", 32'(ext_irq), 32'd0);

    // Priority ordering with tie to lowest ID: 7 (prio 6), then 2, then 5 (both prio 5)
    cfg_write(6'd2, 32'd5);
    cfg_write(6'd5, 32'd5);
    cfg_write(6'd7, 32'd6);
    cfg_write(6'h20, 32'h52);
    irq_src = 8'h52;
    step();
    step();
    chk("arb_irq", 32'(ext_irq), 32'd1);
    do_claim("arb_c1", 5'd7);
    do_claim("arb_c2", 5'd2);
    do_claim("arb_c3", 5'd5);
    do_claim("arb_c4", 5'd0);
    step();
    chk("arb_irq_idle", 32'(ext_irq), 32'd0);
    irq_src = '0;
    do_complete(5'd7);
    do_complete(5'd2);
    do_complete(5'd5);

    // Threshold boundary: prio equal to threshold never interrupts
    cfg_write(6'h21, 32'd5);
    cfg_write(6'd4, 32'd5);
    cfg_write(6'h20, 32'h08);
    cfg_check("rd_thr", 6'h21, 32'd5);
    irq_src = 8'h08;
    repeat (3) step();
    chk("thr_eq_blocks", 32'(ext_irq), 32'd0);
    cfg_write(6'h21, 32'd4);
    chk("thr_write_edge", 32'(ext_irq), 32'd0);
    step();
    chk("thr_lowered", 32'(ext_irq), 32'd1);
    do_claim("thr_claim", 5'd4);
    irq_src = '0;
    do_complete(5'd4);

    // Source 1: disable keeps pending, invalid complete ignored, valid complete re-pends
    cfg_write(6'h21, 32'd0);
    cfg_write(6'd1, 32'd1);
    cfg_write(6'h20, 32'h01);
    irq_src = 8'h01;
    step();
    step();
    chk("s1_irq", 32'(ext_irq), 32'd1);
    cfg_write(6'h20, 32'h00);
    step();
    chk("s1_disabled", 32'(ext_irq), 32'd0);
    cfg_write(6'h20, 32'h01);
    step();
    chk("s1_reenabled", 32'(ext_irq), 32'd1);
    do_claim("s1_claim", 5'd1);
    step();
    chk("s1_inflight", 32'(ext_irq), 32'd0);
    do_complete(5'd9);
    step();
    step();
    chk("s1_cpl9_ignored", 32'(ext_irq), 32'd0);
    do_claim("s1_empty", 5'd0);
    do_complete(5'd1);
    step();
    chk("s1_repend_lat", 32'(ext_irq), 32'd0);
    step();
    chk("s1_repend", 32'(ext_irq), 32'd1);
    do_claim("s1_reclaim", 5'd1);
    irq_src = '0;
    do_complete(5'd1);

    // Single-cycle pulse on source 6 (edge gateway or level latch)
    cfg_write(6'd6, 32'd3);
    cfg_write(6'h20, 32'h20);
    cfg_write(6'h22, 32'h20);
`ifdef PLIC_EDGE_TRIG_EN
    cfg_check("rd_edge_mode", 6'h22, 32'h20);
`else
    cfg_check("rd_edge_mode", 6'h22, 32'h00);
`endif
    irq_src = 8'h20;
    step();
    irq_src = '0;
    step();
    step();
    chk("s6_irq", 32'(ext_irq), 32'd1);
    do_claim("s6_claim", 5'd6);
    do_claim("s6_again", 5'd0);
    do_complete(5'd6);

    // Mid-operation reset clears pending and configuration
    irq_src = 8'h20;
    step();
    step();
    chk("pre_rst_irq", 32'(ext_irq), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    irq_src = '0;
    chk("mid_rst_irq", 32'(ext_irq), 32'd0);
    cfg_check("mid_rst_enable", 6'h20, 32'd0);
    do_claim("mid_rst_claim", 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
